// File: rtl/pattern_sequencer.sv
// Modulo-N up/down counter that walks a small pattern memory, presenting the
// addressed word and one selected bit of it with one cycle of latency.
module pattern_sequencer #(
   parameter int CNT_W   = 4,
   parameter int MODULUS = 10,
   parameter int DATA_W  = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              EN,
   input  logic              UP,
   input  logic              LOAD,
   input  logic [CNT_W-1:0]  LOAD_VAL,
   input  logic              WE,
   input  logic [CNT_W-1:0]  WADDR,
   input  logic [DATA_W-1:0] WDATA,
   output logic [CNT_W-1:0]  Q_OUT,
   output logic [DATA_W-1:0] D_OUT,
   output logic              OUT,
   output logic              TC
);

   localparam int DEPTH = 2 ** CNT_W;
   // One extra bit so that MODULUS == DEPTH is still representable.
   localparam logic [CNT_W:0]   MOD_EXT = (CNT_W + 1)'(MODULUS);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(MODULUS - 1);

   logic [DATA_W-1:0] mem      [DEPTH];
   logic [DATA_W-1:0] init_pat [DEPTH];

   logic [CNT_W-1:0]  q_reg, q_next;
   logic [DATA_W-1:0] d_reg;
   logic              out_reg;
   logic              tc_reg, tc_next;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] sel_mask;
   logic              rd_bit;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_init
         assign init_pat[gi] = DATA_W'(1) << (gi % DATA_W);
      end
   endgenerate

   always_comb begin
      rd_word  = mem[q_reg];
      sel_mask = DATA_W'(1) << (int'(q_reg) % DATA_W);
      rd_bit   = |(rd_word & sel_mask);
   end

   // Load beats count; a wrap only raises TC when it is a genuine count step.
   always_comb begin
      q_next  = q_reg;
      tc_next = 1'b0;
      if (LOAD) begin
         q_next = ({1'b0, LOAD_VAL} < MOD_EXT) ? LOAD_VAL : '0;
      end else if (EN) begin
         if (UP) begin
            if (q_reg == LAST) begin
               q_next  = '0;
               tc_next = 1'b1;
            end else begin
               q_next = q_reg + 1'b1;
            end
         end else begin
            if (q_reg == '0) begin
               q_next  = LAST;
               tc_next = 1'b1;
            end else begin
               q_next = q_reg - 1'b1;
            end
         end
      end
   end

   // The read above sees the pre-edge contents, so a same-edge write to the
   // current address returns the old word.
   always_ff @(negedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= init_pat[i];
         end
      end else if (WE) begin
         mem[WADDR] <= WDATA;
      end
   end

   always_ff @(negedge CLK) begin
      if (!RST_N) begin
         q_reg   <= '0;
         d_reg   <= '0;
         out_reg <= 1'b0;
         tc_reg  <= 1'b0;
      end else begin
         q_reg   <= q_next;
         d_reg   <= rd_word;
         out_reg <= rd_bit;
         tc_reg  <= tc_next;
      end
   end

   assign Q_OUT = q_reg;
   assign D_OUT = d_reg;
   assign OUT   = out_reg;
   assign TC    = tc_reg;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer at default parameters; inputs change
// and outputs are sampled just after the rising edge, state moves on falling.
module tb_pattern_sequencer;

   logic        CLK;
   logic        RST_N;
   logic        EN;
   logic        UP;
   logic        LOAD;
   logic [3:0]  LOAD_VAL;
   logic        WE;
   logic [3:0]  WADDR;
   logic [15:0] WDATA;
   logic [3:0]  Q_OUT;
   logic [15:0] D_OUT;
   logic        OUT;
   logic        TC;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   pattern_sequencer #(
      .CNT_W   (4),
      .MODULUS (10),
      .DATA_W  (16)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .EN       (EN),
      .UP       (UP),
      .LOAD     (LOAD),
      .LOAD_VAL (LOAD_VAL),
      .WE       (WE),
      .WADDR    (WADDR),
      .WDATA    (WDATA),
      .Q_OUT    (Q_OUT),
      .D_OUT    (D_OUT),
      .OUT      (OUT),
      .TC       (TC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // One falling (active) edge, then settle just past the following rising edge.
   task automatic step();
      @(negedge CLK);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      EN = 1'b0; UP = 1'b1; LOAD = 1'b0; LOAD_VAL = '0;
      WE = 1'b0; WADDR = '0; WDATA = '0;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0;
      idle_inputs();
      @(posedge CLK);
      #1;
      step();
      check_val("rst_q",   32'(Q_OUT), 32'd0);
      check_val("rst_d",   32'(D_OUT), 32'd0);
      check_val("rst_out", 32'(OUT),   32'd0);
      check_val("rst_tc",  32'(TC),    32'd0);
      RST_N = 1'b1;

      // Up count through the wrap; identity pattern makes OUT=1 each step.
      EN = 1'b1; UP = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         check_val($sformatf("up%0d_q", k),   32'(Q_OUT), 32'(k % 10));
         check_val($sformatf("up%0d_tc", k),  32'(TC),    (k == 10) ? 32'd1 : 32'd0);
         check_val($sformatf("up%0d_out", k), 32'(OUT),   32'd1);
         check_val($sformatf("up%0d_d", k),   32'(D_OUT), 32'd1 << ((k - 1) % 10));
      end

      // Down count from reset wraps 0 -> 9 first.
      idle_inputs();
      do_reset();
      EN = 1'b1; UP = 1'b0;
      step();
      check_val("dn1_q", 32'(Q_OUT), 32'd9);
      check_val("dn1_tc", 32'(TC), 32'd1);
      step();
      check_val("dn2_q", 32'(Q_OUT), 32'd8);
      check_val("dn2_tc", 32'(TC), 32'd0);
      step();
      check_val("dn3_q", 32'(Q_OUT), 32'd7);
      check_val("dn3_d", 32'(D_OUT), 32'h0100);

      // Loads: legal, load-over-wrapping-enable, hold, out-of-range.
      idle_inputs();
      LOAD = 1'b1; LOAD_VAL = 4'd9;
      step();
      check_val("ld9_q", 32'(Q_OUT), 32'd9);
      LOAD_VAL = 4'd7; EN = 1'b1; UP = 1'b1;
      step();
      check_val("ld7en_q", 32'(Q_OUT), 32'd7);
      check_val("ld7en_tc", 32'(TC), 32'd0);
      idle_inputs();
      step();
      step();
      check_val("hold_q", 32'(Q_OUT), 32'd7);
      LOAD = 1'b1; LOAD_VAL = 4'd12;
      step();
      check_val("ld12_q", 32'(Q_OUT), 32'd0);

      // Write mem[3]=0 while counter holds, then read it back on the way up.
      idle_inputs();
      do_reset();
      WE = 1'b1; WADDR = 4'd3; WDATA = 16'h0000;
      step();
      WE = 1'b0; EN = 1'b1; UP = 1'b1;
      for (int k = 0; k < 4; k++) step();
      check_val("w3_q", 32'(Q_OUT), 32'd4);
      check_val("w3_d", 32'(D_OUT), 32'h0000);
      check_val("w3_out", 32'(OUT), 32'd0);
      idle_inputs();
      do_reset();
      EN = 1'b1; UP = 1'b1;
      for (int k = 0; k < 4; k++) step();
      check_val("r3_d", 32'(D_OUT), 32'h0008);
      check_val("r3_out", 32'(OUT), 32'd1);

      // Collision at address 5: old word now, new word on the next pass.
      for (int k = 0; k < 1; k++) step();
      check_val("pre5_q", 32'(Q_OUT), 32'd5);
      WE = 1'b1; WADDR = 4'd5; WDATA = 16'hFFFF;
      step();
      WE = 1'b0;
      check_val("col_q", 32'(Q_OUT), 32'd6);
      check_val("col_d", 32'(D_OUT), 32'h0020);
      check_val("col_out", 32'(OUT), 32'd1);
      for (int k = 0; k < 10; k++) step();
      check_val("pass5_q", 32'(Q_OUT), 32'd6);
      check_val("pass5_d", 32'(D_OUT), 32'hFFFF);

      // Reset mid-count at Q=6 with load/write requests that must be ignored.
      RST_N = 1'b0; LOAD = 1'b1; LOAD_VAL = 4'd3;
      WE = 1'b1; WADDR = 4'd0; WDATA = 16'h1234;
      step();
      check_val("mr_q",   32'(Q_OUT), 32'd0);
      check_val("mr_tc",  32'(TC),    32'd0);
      check_val("mr_d",   32'(D_OUT), 32'd0);
      check_val("mr_out", 32'(OUT),   32'd0);
      RST_N = 1'b1;
      idle_inputs();
      EN = 1'b1; UP = 1'b1;
      step();
      check_val("res1_q", 32'(Q_OUT), 32'd1);
      check_val("res1_d", 32'(D_OUT), 32'h0001);
      step();
      check_val("res2_q", 32'(Q_OUT), 32'd2);
      for (int k = 0; k < 4; k++) step();
      check_val("res6_d", 32'(D_OUT), 32'h0020);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
